dram_arbiter: RTL and testbench

//  Shares the single-port data memory between NUM_PORTS requesters (core data ports, loader).

---
 rtl/dram_arbiter_pkg.sv | 17 +
 rtl/dram_arbiter_rr.sv | 33 +++
 rtl/dram_arbiter.sv | 170 +++++++++++++++++
 tb/tb_dram_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_arbiter_pkg.sv
// Shared types and helpers for the data-memory arbiter.
package dram_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam int unsigned GrantCntW = 16;

  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/dram_arbiter_rr.sv
// Combinational rotating-priority picker: first requester at or after ptr_i, wrapping.
module dram_arbiter_rr #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned PtrW      = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [PtrW-1:0]      ptr_i,
  output logic                 valid_o,
  output logic [NUM_PORTS-1:0] gnt_oh_o,
  output logic [PtrW-1:0]      idx_o
);

  logic            found;
  logic [PtrW-1:0] j;

  always_comb begin
    gnt_oh_o = '0;
    idx_o    = '0;
    found    = 1'b0;
    j        = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      j = PtrW'((32'(ptr_i) + i) % NUM_PORTS);
      if (!found && req_i[j]) begin
        found       = 1'b1;
        gnt_oh_o[j] = 1'b1;
        idx_o       = j;
      end
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing a single-port data RAM with fixed read latency.
// Optional per-port grant counters are built when DRAM_ARB_PERF_EN is defined.
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned RD_LAT    = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_PORTS-1:0]          req_i,
  input  logic [NUM_PORTS-1:0]          we_i,
  input  logic [NUM_PORTS*ADDR_W-1:0]   addr_i,
  input  logic [NUM_PORTS*DATA_W-1:0]   wdata_i,
  output logic [NUM_PORTS-1:0]          gnt_o,
  output logic [NUM_PORTS-1:0]          ack_o,
  output logic [DATA_W-1:0]             rdata_o,
  output logic [ADDR_W-1:0]             mem_addr_o,
  output logic [DATA_W-1:0]             mem_wdata_o,
  output logic                          mem_we_o,
  output logic                          mem_re_o,
  input  logic [DATA_W-1:0]             mem_rdata_i,
  output logic [NUM_PORTS*GrantCntW-1:0] grant_cnt_o
);

  localparam int unsigned PtrW = $clog2(NUM_PORTS);
  localparam int unsigned LatW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0]   winner_q, winner_d;
  logic              we_l_q, we_l_d;
  logic [ADDR_W-1:0] addr_l_q, addr_l_d;
  logic [DATA_W-1:0] wdata_l_q, wdata_l_d;
  logic [LatW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic                 arb_valid;
  logic [NUM_PORTS-1:0] arb_oh;
  logic [PtrW-1:0]      arb_idx;
  logic                 sel_we;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;
  logic [NUM_PORTS-1:0] win_oh;

  dram_arbiter_rr #(
    .NUM_PORTS (NUM_PORTS),
    .PtrW      (PtrW)
  ) u_rr (
    .req_i    (req_i),
    .ptr_i    (rr_ptr_q),
    .valid_o  (arb_valid),
    .gnt_oh_o (arb_oh),
    .idx_o    (arb_idx)
  );

  // Mux the winning port's request fields and decode the latched winner.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    win_oh    = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (arb_oh[i]) begin
        sel_we    = we_i[i];
        sel_addr  = addr_i[i*ADDR_W +: ADDR_W];
        sel_wdata = wdata_i[i*DATA_W +: DATA_W];
      end
      win_oh[i] = (winner_q == PtrW'(i));
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    winner_d  = winner_q;
    we_l_d    = we_l_q;
    addr_l_d  = addr_l_q;
    wdata_l_d = wdata_l_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          winner_d  = arb_idx;
          we_l_d    = sel_we;
          addr_l_d  = sel_addr;
          wdata_l_d = sel_wdata;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        rr_ptr_d = PtrW'(wrap_inc(32'(winner_q), NUM_PORTS));
        cnt_d    = LatW'(RD_LAT - 1);
        state_d  = we_l_q ? StDone : StWait;
      end
      StWait: begin
        // Last wait cycle is exactly RD_LAT cycles after issue: RAM data is valid now.
        if (cnt_q == '0) begin
          rdata_d = mem_rdata_i;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      rr_ptr_q  <= '0;
      winner_q  <= '0;
      we_l_q    <= 1'b0;
      addr_l_q  <= '0;
      wdata_l_q <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      winner_q  <= winner_d;
      we_l_q    <= we_l_d;
      addr_l_q  <= addr_l_d;
      wdata_l_q <= wdata_l_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
    end
  end

  assign gnt_o       = (state_q == StIssue) ? win_oh : '0;
  assign ack_o       = (state_q == StDone) ? win_oh : '0;
  assign mem_we_o    = (state_q == StIssue) && we_l_q;
  assign mem_re_o    = (state_q == StIssue) && !we_l_q;
  assign mem_addr_o  = addr_l_q;
  assign mem_wdata_o = wdata_l_q;
  assign rdata_o     = rdata_q;

`ifdef DRAM_ARB_PERF_EN
  logic [NUM_PORTS-1:0][GrantCntW-1:0] gcnt_q, gcnt_d;

  always_comb begin
    gcnt_d = gcnt_q;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (gnt_o[i] && (gcnt_q[i] != '1)) begin
        gcnt_d[i] = gcnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gcnt_q <= '0;
    end else begin
      gcnt_q <= gcnt_d;
    end
  end

  assign grant_cnt_o = gcnt_q;
`else
  assign grant_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dram_arbiter.sv
// Scoreboard bench for dram_arbiter: directed transactions, monitor checks grants and acks.
module tb_dram_arbiter;

  localparam int unsigned NP     = 2;
  localparam int unsigned RD_LAT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    req_i = '0;
  logic [1:0]    we_i = '0;
  logic [31:0]   addr_i = '0;
  logic [31:0]   wdata_i = '0;
  logic [1:0]    gnt_o;
  logic [1:0]    ack_o;
  logic [15:0]   rdata_o;
  logic [15:0]   mem_addr_o;
  logic [15:0]   mem_wdata_o;
  logic          mem_we_o;
  logic          mem_re_o;
  logic [15:0]   mem_rdata_i;
  logic [31:0]   grant_cnt_o;

  dram_arbiter #(
    .NUM_PORTS (NP),
    .ADDR_W    (16),
    .DATA_W    (16),
    .RD_LAT    (RD_LAT)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .gnt_o       (gnt_o),
    .ack_o       (ack_o),
    .rdata_o     (rdata_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_we_o    (mem_we_o),
    .mem_re_o    (mem_re_o),
    .mem_rdata_i (mem_rdata_i),
    .grant_cnt_o (grant_cnt_o)
  );

  always #5 clk = ~clk;

  // Data RAM model: data valid exactly RD_LAT cycles after the mem_re cycle, junk otherwise.
  logic [15:0] ram [256];
  logic [15:0] pipe_d [RD_LAT];
  logic        pipe_v [RD_LAT];
  int          cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc == 0) ram[1] <= 16'd3;
    if (mem_we_o) ram[mem_addr_o[7:0]] <= mem_wdata_o;
    pipe_d[0] <= ram[mem_addr_o[7:0]];
    pipe_v[0] <= mem_re_o;
    for (int k = 1; k < int'(RD_LAT); k++) begin
      pipe_d[k] <= pipe_d[k-1];
      pipe_v[k] <= pipe_v[k-1];
    end
  end
  assign mem_rdata_i = pipe_v[RD_LAT-1] ? pipe_d[RD_LAT-1] : 16'hDEAD;

  typedef struct packed {
    logic [2:0]  port;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } gnt_exp_t;

  typedef struct packed {
    logic [2:0]  port;
    logic        rd;
    logic [15:0] rdata;
  } ack_exp_t;

  gnt_exp_t gnt_q[$];
  ack_exp_t ack_q[$];
  int       checks = 0;
  int       errors = 0;
  int       gnt_cyc [NP];
  logic [15:0] model_rdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a grant or an ack.
  always @(negedge clk) begin
    gnt_exp_t g;
    ack_exp_t a;
    if (rst) model_rdata = '0;
    check("we_re_exclusive", 32'(mem_we_o & mem_re_o), 32'd0);
    if (gnt_o != '0) begin
      if (gnt_q.size() == 0) begin
        check("unexpected_gnt", 32'(gnt_o), 32'd0);
      end else begin
        g = gnt_q.pop_front();
        check("gnt_port", 32'(gnt_o), 32'd1 << g.port);
        check("mem_we", 32'(mem_we_o), 32'(g.we));
        check("mem_re", 32'(mem_re_o), 32'(!g.we));
        check("mem_addr", 32'(mem_addr_o), 32'(g.addr));
        if (g.we) check("mem_wdata", 32'(mem_wdata_o), 32'(g.wdata));
        gnt_cyc[g.port[0]] = cyc;
      end
    end
    if (ack_o != '0) begin
      if (ack_q.size() == 0) begin
        check("unexpected_ack", 32'(ack_o), 32'd0);
      end else begin
        a = ack_q.pop_front();
        check("ack_port", 32'(ack_o), 32'd1 << a.port);
        check("gnt_to_ack", 32'(cyc - gnt_cyc[a.port[0]]), a.rd ? 32'(1 + RD_LAT) : 32'd1);
        if (a.rd) model_rdata = a.rdata;
        check("rdata", 32'(rdata_o), 32'(model_rdata));
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    req_i = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Raise the masked requests, drop each one after its grant, wait for all expected acks.
  task automatic run(input logic [1:0] mask, input logic [1:0] w, input logic [31:0] a,
                     input logic [31:0] d);
    logic [1:0] pend;
    int n;
    int first;
    @(posedge clk);
    #1;
    we_i = w;
    addr_i = a;
    wdata_i = d;
    req_i = mask;
    pend = mask;
    first = 0;
    n = 0;
    while ((pend != 0 || ack_q.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
      if ((pend & gnt_o) != 0 && first == 0) first = n;
      pend = pend & ~gnt_o;
      @(posedge clk);
      #1 req_i = pend;
    end
    check("txn_complete", 32'(n < 60), 32'd1);
    if ($countones(mask) == 1) check("req_to_gnt", 32'(first), 32'd2);
  endtask

  initial begin
    int n;
    int gcount;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_gnt", 32'(gnt_o), 32'd0);
    check("rst_ack", 32'(ack_o), 32'd0);
    check("rst_rdata", 32'(rdata_o), 32'd0);
    check("rst_mem_addr", 32'(mem_addr_o), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata_o), 32'd0);
    check("rst_mem_we", 32'(mem_we_o), 32'd0);
    check("rst_mem_re", 32'(mem_re_o), 32'd0);
    check("rst_grant_cnt", grant_cnt_o, 32'd0);

    // Single read, port0, RAM[1]=3
    gnt_q.push_back('{port: 3'd0, we: 1'b0, addr: 16'd1, wdata: 16'd0});
    ack_q.push_back('{port: 3'd0, rd: 1'b1, rdata: 16'd3});
    run(2'b01, 2'b00, {16'd0, 16'd1}, 32'd0);

    // Single write, port1; rdata must keep 3
    gnt_q.push_back('{port: 3'd1, we: 1'b1, addr: 16'd5, wdata: 16'h00AB});
    ack_q.push_back('{port: 3'd1, rd: 1'b0, rdata: 16'd0});
    run(2'b10, 2'b10, {16'd5, 16'd0}, {16'h00AB, 16'd0});

    // Read back the write on port1
    gnt_q.push_back('{port: 3'd1, we: 1'b0, addr: 16'd5, wdata: 16'd0});
    ack_q.push_back('{port: 3'd1, rd: 1'b1, rdata: 16'h00AB});
    run(2'b10, 2'b00, {16'd5, 16'd0}, 32'd0);

    // Contention after reset: port0 (read) first, then port1 (write)
    do_reset();
    gnt_q.push_back('{port: 3'd0, we: 1'b0, addr: 16'd1, wdata: 16'd0});
    ack_q.push_back('{port: 3'd0, rd: 1'b1, rdata: 16'd3});
    gnt_q.push_back('{port: 3'd1, we: 1'b1, addr: 16'd7, wdata: 16'h0055});
    ack_q.push_back('{port: 3'd1, rd: 1'b0, rdata: 16'd0});
    run(2'b11, 2'b10, {16'd7, 16'd1}, {16'h0055, 16'd0});

    // Fairness: both ports request continuously for six writes
    do_reset();
    for (int k = 0; k < 6; k++) begin
      gnt_q.push_back('{port: 3'(k % 2), we: 1'b1, addr: 16'(20 + k % 2),
                        wdata: (k % 2 == 0) ? 16'h1111 : 16'h2222});
      ack_q.push_back('{port: 3'(k % 2), rd: 1'b0, rdata: 16'd0});
    end
    @(posedge clk);
    #1;
    we_i = 2'b11;
    addr_i = {16'd21, 16'd20};
    wdata_i = {16'h2222, 16'h1111};
    req_i = 2'b11;
    gcount = 0;
    n = 0;
    while (gcount < 6 && n < 100) begin
      @(negedge clk);
      n++;
      if (gnt_o != '0) gcount++;
    end
    @(posedge clk);
    #1 req_i = '0;
    n = 0;
    while (ack_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("fair_grants", 32'(gcount), 32'd6);
    check("fair_acks_left", 32'(ack_q.size()), 32'd0);

    // Reset while a read is waiting on the RAM: no ack, outputs back to reset values
    gnt_q.push_back('{port: 3'd0, we: 1'b0, addr: 16'd5, wdata: 16'd0});
    @(posedge clk);
    #1;
    we_i = 2'b00;
    addr_i = {16'd0, 16'd5};
    req_i = 2'b01;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt_o == '0 && n < 10);
    check("wait_rst_gnt_seen", 32'(gnt_o), 32'b01);
    @(posedge clk);
    #1;
    req_i = '0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("wait_rst_ack", 32'(ack_o), 32'd0);
    check("wait_rst_mem_re", 32'(mem_re_o), 32'd0);
    check("wait_rst_rdata", 32'(rdata_o), 32'd0);
    check("wait_rst_mem_addr", 32'(mem_addr_o), 32'd0);
    repeat (4) @(negedge clk);
    gnt_q.push_back('{port: 3'd1, we: 1'b0, addr: 16'd7, wdata: 16'd0});
    ack_q.push_back('{port: 3'd1, rd: 1'b1, rdata: 16'h0055});
    run(2'b10, 2'b00, {16'd7, 16'd0}, 32'd0);

    // Grant counters: three grants to port1 only
    do_reset();
    for (int k = 0; k < 3; k++) begin
      gnt_q.push_back('{port: 3'd1, we: 1'b1, addr: 16'd30, wdata: 16'h0303});
      ack_q.push_back('{port: 3'd1, rd: 1'b0, rdata: 16'd0});
      run(2'b10, 2'b10, {16'd30, 16'd0}, {16'h0303, 16'd0});
    end
    @(negedge clk);
`ifdef DRAM_ARB_PERF_EN
    check("grant_cnt_p1", 32'(grant_cnt_o[31:16]), 32'd3);
`else
    check("grant_cnt_p1", 32'(grant_cnt_o[31:16]), 32'd0);
`endif
    check("grant_cnt_p0", 32'(grant_cnt_o[15:0]), 32'd0);

    repeat (3) @(negedge clk);
    check("gnt_queue_empty", 32'(gnt_q.size()), 32'd0);
    check("ack_queue_empty", 32'(ack_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
